// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion path and the downstream
// seven-segment driver (which reuses bcd_digit_t).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell: digits 5..9 get +3 before the shift so
// that the doubled value carries correctly into the next decade.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= ADD3_THRESH) ? din + ADD3_VAL : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional leading-zero blank mask is enabled by defining LEADING_ZERO_BLANK_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   count;
  logic               ovf_sr;
  logic [BCD_W+BIN_W:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_sr[i*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Top bit is whatever falls out of the most significant digit this shift.
  assign shifted = {bcd_adj, bin_sr, 1'b0};

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  // Digit 0 is never blanked so a zero result still shows a single "0".
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
    logic zero_above;
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (b[i*DIGIT_W +: DIGIT_W] == '0);
      blank_mask[i] = zero_above;
    end
  endfunction

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      count   <= '0;
      ovf_sr  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            ovf_sr <= 1'b0;
            count  <= CNT_W'(BIN_W);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          bcd_sr <= shifted[BCD_W+BIN_W-1:BIN_W];
          bin_sr <= shifted[BIN_W-1:0];
          ovf_sr <= ovf_sr | shifted[BCD_W+BIN_W];
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          bcd_out <= bcd_sr;
          ovf     <= ovf_sr;
          done    <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          blank_q <= blank_mask(bcd_sr);
`endif
          // Back-to-back accept keeps throughput at one result per BIN_W+1 clocks.
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            ovf_sr <= 1'b0;
            count  <= CNT_W'(BIN_W);
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;

  logic        busy, done, ovf;
  logic [11:0] bcd_out;
  logic [2:0]  blank;

  logic        busy2, done2, ovf2;
  logic [7:0]  bcd_out2;
  logic [1:0]  blank2;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf), .blank(blank)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2), .blank(blank2)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [2:0] BLK_0  = 3'b110;
  localparam logic [2:0] BLK_7  = 3'b110;
  localparam logic [2:0] BLK_42 = 3'b100;
  localparam logic [1:0] BLK2_200 = 2'b10;
`else
  localparam logic [2:0] BLK_0  = 3'b000;
  localparam logic [2:0] BLK_7  = 3'b000;
  localparam logic [2:0] BLK_42 = 3'b000;
  localparam logic [1:0] BLK2_200 = 2'b00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Decimal digits by plain division; result kept modulo 10^nd.
  function automatic void ref_conv(input int v, input int nd, output logic [11:0] bcd,
                                   output logic ov, output logic [2:0] blk);
    int p, t, d, pw;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    t   = v % p;
    ov  = (v >= p);
    bcd = '0;
    blk = '0;
    d   = t;
    for (int i = 0; i < nd; i++) begin
      bcd[i*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    pw = 1;
    for (int i = 1; i < nd; i++) begin
      pw = pw * 10;
      blk[i] = ((t / pw) == 0);
    end
`else
    pw = 0;
`endif
  endfunction

  // Timing model: edges remaining until the result appears (0 = idle).
  int          rem = 0;
  int          prev;
  int          pend_v = 0;
  logic        m_done = 1'b0, m_busy = 1'b0;
  logic [11:0] m_bcd3 = '0, m_bcd2 = '0;
  logic        m_ovf3 = 1'b0, m_ovf2 = 1'b0;
  logic [2:0]  m_blk3 = '0, m_blk2 = '0;

  always @(posedge clk) begin
    prev   = rem;
    m_done = 1'b0;
    if (rst) begin
      rem = 0;
      m_bcd3 = '0; m_bcd2 = '0; m_ovf3 = 1'b0; m_ovf2 = 1'b0; m_blk3 = '0; m_blk2 = '0;
    end else begin
      if (prev == 1) begin
        ref_conv(pend_v, 3, m_bcd3, m_ovf3, m_blk3);
        ref_conv(pend_v, 2, m_bcd2, m_ovf2, m_blk2);
        m_done = 1'b1;
        rem = 0;
      end else if (prev > 1) begin
        rem = prev - 1;
      end
      if ((prev == 0 || prev == 1) && start) begin
        pend_v = int'(bin_in);
        rem = 9;
      end
    end
    m_busy = (rem >= 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done",    done,     m_done);
      check("busy",    busy,     m_busy);
      check("bcd_out", bcd_out,  m_bcd3);
      check("ovf",     ovf,      m_ovf3);
      check("blank",   blank,    m_blk3);
      check("done2",   done2,    m_done);
      check("busy2",   busy2,    m_busy);
      check("bcd_out2", bcd_out2, m_bcd2[7:0]);
      check("ovf2",    ovf2,     m_ovf2);
      check("blank2",  blank2,   m_blk2[1:0]);
    end
  end

  task automatic run(input int v, output int lat, output int bcnt);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'(v);
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, ndone, lat2;
    logic [11:0] rb;
    logic        ro;
    logic [2:0]  rk;

    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd",  bcd_out, 12'h000);
    check("rst_ovf",  ovf, 1'b0);
    check("rst_blank", blank, 3'b000);
    rst = 1'b0;

    // Model pinning: hand-computed values.
    ref_conv(255, 3, rb, ro, rk);
    check("model_255", rb, 12'h255);
    ref_conv(200, 2, rb, ro, rk);
    check("model_200_d2", {ro, rb[7:0]}, 9'h100);

    run(255, lat, bc);
    check("lat_255", lat, 9);
    check("busy_cycles_255", bc, 8);
    check("bcd_255", bcd_out, 12'h255);
    check("ovf_255", ovf, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    run(0, lat, bc);
    check("bcd_0", bcd_out, 12'h000);
    check("blank_0", blank, BLK_0);
    run(7, lat, bc);
    check("bcd_7", bcd_out, 12'h007);
    check("blank_7", blank, BLK_7);
    run(42, lat, bc);
    check("bcd_42", bcd_out, 12'h042);
    check("blank_42", blank, BLK_42);

    // start during busy is ignored
    @(negedge clk);
    start = 1'b1; bin_in = 8'd100;
    @(posedge clk);
    ndone = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (i == 3) bin_in = 8'd77;
      if (done) begin
        ndone++;
        check("bcd_100", bcd_out, 12'h100);
      end
    end
    check("single_done", ndone, 1);

    // reset mid-conversion
    @(negedge clk);
    start = 1'b1; bin_in = 8'd200;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_bcd", bcd_out, 12'h000);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run(199, lat, bc);
    check("bcd_199", bcd_out, 12'h199);

    // back-to-back accept
    @(negedge clk);
    start = 1'b1; bin_in = 8'd45;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bin_in = 8'd99;
      if (done) begin
        lat = i - 1;
        check("b2b_first", bcd_out, 12'h045);
        break;
      end
    end
    start = 1'b0;
    check("b2b_lat1", lat, 9);
    lat2 = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done) begin
        lat2 = j;
        break;
      end
    end
    check("b2b_lat2", lat + lat2, 18);
    check("b2b_second", bcd_out, 12'h099);

    // two-digit instance overflow
    run(200, lat, bc);
    check("d2_bcd_200", bcd_out2, 8'h00);
    check("d2_ovf_200", ovf2, 1'b1);
    check("d2_blank_200", blank2, BLK2_200);
    run(99, lat, bc);
    check("d2_bcd_99", bcd_out2, 8'h99);
    check("d2_ovf_99", ovf2, 1'b0);

    // exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      run(v, lat, bc);
      ref_conv(v, 3, rb, ro, rk);
      check("sweep_lat", lat, 9);
      check("sweep_bcd", bcd_out, rb);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the double-dabble algorithm, one shift per clock. It sits directly upstream of the D7S multiplexed seven-segment driver. It converts a binary value into DIGITS packed BCD digits, which feed the D7S digit mux (one digit per transistor select line). Results are held stable between conversions so the display never shows partial values.

Parameters:
BIN_W, 8, width of the binary input
DIGITS, 3, number of BCD output digits (4 bits each); digit 0 is the least significant

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  conversion request; sampled on rising clk
bin_in  input  BIN_W  binary value; captured on the accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out is updated
bcd_out  output  4*DIGITS  packed BCD result; [3:0] is digit 0; registered and held
ovf  output  1  result exceeded 10^DIGITS-1; valid with done, then held
blank  output  DIGITS  leading-zero blank mask, one bit per digit (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, and dominant over all other inputs. On reset: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, blank=0. Internal shift registers are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, capture bin_in into shift register bin_sr, clear scratch register bcd_sr, set count=BIN_W, and go to SHIFT. busy goes to 1 on the next cycle.
- SHIFT, each cycle:
  - For every 4-bit digit of bcd_sr that is >=5, add 3 (all digits corrected in parallel).
  - Then shift {bcd_sr, bin_sr} left by 1.
  - The bit shifted out of the top digit is ORed into a sticky ovf_sr.
  - Decrement count. When the decremented count reaches 0, go to DONE.
- DONE: held for 1 cycle.
  - bcd_out<=bcd_sr, ovf<=ovf_sr, blank updated, done=1, busy=0.
  - Then go to IDLE, or go straight to SHIFT if start=1 in this cycle (back-to-back accept; bin_in captured as in IDLE).
- Latency: start sampled at edge k -> busy=1 during cycles k+1..k+BIN_W -> done=1 and new bcd_out visible after edge k+BIN_W+1. With BIN_W=8 that is 9 clocks.
- Throughput: one conversion per BIN_W+1 clocks.
- start while in SHIFT is ignored; no queuing. bin_in is don't-care outside the accept cycle.
- bcd_out, ovf and blank change only in the DONE cycle or on reset.
- ovf: set if any 1 is shifted out of the top digit. bcd_out then holds the low DIGITS digits (modulo 10^DIGITS). With the defaults, ovf can never be set (255 < 1000).
- Reset mid-conversion: aborts immediately to the reset values. No done is produced for the aborted conversion.
- Arithmetic: the add-3 correction is 4 bits wide and never overflows a digit for inputs 5..9. count is $clog2(BIN_W+1) bits wide.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at DONE, blank[i]=1 when digit i and all higher digits are 0, for i>=1. blank[0] is always 0, so value 0 shows a single "0". D7S uses blank to turn segments off.
- Undefined: blank is tied to all zeros and no mask logic is synthesized. The port remains present so the top-level wiring is identical either way.

Decomposition:
- Shared package bcd_pkg contains:
  - typedef of the FSM state enum (IDLE, SHIFT, DONE);
  - localparam DIGIT_W=4;
  - localparam ADD3_THRESH=4'd5;
  - localparam ADD3_VAL=4'd3;
  - a BCD digit typedef (logic [3:0]), also used by D7S.
- One sub-module: bcd_add3, a purely combinational digit correction cell (in>=5 ? in+3 : in). It is instantiated DIGITS times via generate.

Test Plan:
- Latency and done pulse: bin_in=255, start pulse -> done exactly 9 clocks later; bcd_out=12'h255, ovf=0; busy high for 8 cycles; done high for 1 cycle.
- Zero input: bin_in=0 -> bcd_out=12'h000. With LEADING_ZERO_BLANK_EN, blank=3'b110. bin_in=7 -> blank=3'b110, bcd_out=12'h007. bin_in=42 -> blank=3'b100.
- Start during busy: start 100, then pulse start with bin_in=77 on cycle 3 -> single done with bcd_out=12'h100; no second done.
- Reset mid-conversion: start 200, assert rst on cycle 4 -> next cycle busy=0 and bcd_out=0; no done. A following start 199 gives 12'h199.
- Back-to-back: start 45, then start=1 held through the DONE cycle with bin_in=99 -> done at clock 9 (12'h045) and at clock 18 (12'h099).
- Overflow and exhaustive sweep: with DIGITS=2, bin_in=200 -> bcd_out=8'h00, ovf=1; bin_in=99 -> ovf=0. With the defaults, sweep all 0..255 against a reference model.
